// File: rtl/pwm3_pkg.sv
// pwm3 shared types and constants.
// Holds the FSM encoding and duty helpers.
package pwm3_pkg;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int CW_DEF = 3;

  function automatic int max_duty(input int cw);
    return 1 << cw;
  endfunction

endpackage

// File: rtl/cnt_seq_chk.sv
// Upstream counter sequence checker.
// Flags count_in values that skip the +1 step.
module cnt_seq_chk
  import pwm3_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] count_in,
  input  logic          enable,
  output logic          seq_bad
);

  logic [CW-1:0] prev_q;
  logic [CW-1:0] next_exp;

  assign next_exp = prev_q + 1'b1;
  assign seq_bad  = enable && (count_in != next_exp);

  // remember last count for the next-cycle compare
  always_ff @(posedge clk) begin
    if (!reset) prev_q <= '0;
    else        prev_q <= count_in;
  end

endmodule

// File: rtl/pwm3_gen.sv
// PWM generator locked to an external counter.
// Shadow duty applies at period boundaries.
module pwm3_gen
  import pwm3_pkg::*;
#(
  parameter int CW  = CW_DEF,
  parameter int PCW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [CW-1:0]  count_in,
  input  logic [CW:0]    duty_in,
  input  logic           duty_valid,
  output logic           duty_ready,
  input  logic           err_clr,
  output logic           pwm_out,
  output logic           period_start,
  output logic           seq_err,
  output logic [PCW-1:0] period_cnt
);

  localparam logic [CW:0] DMAX = (CW+1)'(max_duty(CW));

  state_t      state;
  logic [CW:0] active_q;
  logic [CW:0] shadow_q;
  logic        pending_q;
  logic        seq_bad;
  logic        bad;
  logic        bnd;
  logic        accept;
  logic [CW:0] eff;
  logic [CW:0] duty_sat;
  logic [CW:0] cnt_ext;

  cnt_seq_chk #(.CW(CW)) u_chk (
    .clk      (clk),
    .reset    (reset),
    .count_in (count_in),
    .enable   (state == RUN),
    .seq_bad  (seq_bad)
  );

  assign duty_ready = !pending_q;
  assign cnt_ext    = {1'b0, count_in};

  // error / boundary / handshake decode
  always_comb begin
    bad      = (state == RUN) && seq_bad;
    bnd      = !bad && (count_in == '0);
    eff      = pending_q ? shadow_q : active_q;
    accept   = duty_valid && !pending_q;
    duty_sat = (duty_in > DMAX) ? DMAX : duty_in;
  end

  // FSM, duty registers and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= SYNC;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      seq_err      <= 1'b0;
      period_cnt   <= '0;
    end else begin
      if (accept) begin
        shadow_q  <= duty_sat;
        pending_q <= 1'b1;
      end else if (bnd) begin
        pending_q <= 1'b0;
      end
      unique case (1'b1)
        bad: begin
          state        <= SYNC;
          pwm_out      <= 1'b0;
          period_start <= 1'b0;
          seq_err      <= 1'b1;
        end
        bnd: begin
          if (err_clr) seq_err <= 1'b0;
          state        <= RUN;
          active_q     <= eff;
          pwm_out      <= cnt_ext < eff;
          period_start <= 1'b1;
          period_cnt   <= period_cnt + 1'b1;
        end
        default: begin
          if (err_clr) seq_err <= 1'b0;
          period_start <= 1'b0;
          pwm_out      <= (state == RUN)
                          && (cnt_ext < active_q);
        end
      endcase
    end
  end

endmodule
